io_port_bridge: RTL
===================

# io_port_bridge

Memory-side I/O bridge for the 16-bit pipelined processor. It sits at the far end of the processor's external data interface: it accepts store words the memory stage drives on `write_out`, and it supplies load words on `read_in`. Two small FIFOs decouple the processor from external devices. The TX FIFO carries processor stores out to a consumer over a valid/ready handshake. The RX FIFO carries words from an external producer, also over valid/ready, back to processor loads.

## Interface
Parameters:
- `DEPTH`, 4: entries per FIFO; power of two, 2..16.
- `EMPTY_VALUE`, 16'h0000: value driven on `read_in` when the RX FIFO is empty.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `write_out`  in  16  store data from the processor memory stage.
- `cpu_wr`  in  1  processor I/O store strobe; push `write_out` into TX.
- `cpu_rd`  in  1  processor I/O load strobe; pop RX head.
- `read_in`  out  16  load data to the processor; RX head, combinational.
- `tx_data`  out  16  TX FIFO head.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  consumer accepts `tx_data` this cycle.
- `rx_data`  in  16  producer word.
- `rx_valid`  in  1  producer offers `rx_data`.
- `rx_ready`  out  1  RX FIFO not full.
- `cpu_hold`  out  1  processor must repeat the access next cycle (see Configuration).
- `overflow`  out  1  sticky: a store was dropped.
- `underflow`  out  1  sticky: a load hit an empty RX FIFO.

## Operation
- Each FIFO has a register array, read and write pointers of width log2(DEPTH), and a count of width log2(DEPTH)+1 (range 0..DEPTH). Pointers wrap modulo DEPTH.
- TX push: `cpu_wr && (!tx_full || tx_pop)`. A push into a full FIFO is accepted when a pop happens in the same cycle.
- TX pop (`tx_pop`): `tx_valid && tx_ready`.
- TX push and pop in the same cycle leave the count unchanged and advance both pointers.
- RX push: `rx_valid && rx_ready`. `rx_ready = !rx_full`, with no same-cycle pop bypass.
- RX pop: `cpu_rd && !rx_empty`. `read_in` = RX head when non-empty, otherwise `EMPTY_VALUE`.
- No empty-FIFO bypass on either side. A word pushed in cycle N is never visible at the output in cycle N.
- `cpu_wr` and `cpu_rd` may both be asserted in one cycle. They act independently.
- `overflow` and `underflow` are set per Configuration and cleared only by `rst`.

## Timing
- Reset, at the posedge with `rst`=1:
  - counts and pointers go to 0; `overflow` and `underflow` go to 0.
  - Afterwards `tx_valid`=0, `rx_ready`=1, `read_in`=`EMPTY_VALUE`, `cpu_hold`=0, `tx_data`=array[0] (don't-care while `tx_valid`=0).
- Reset mid-operation flushes all buffered words. Strobes asserted in the reset cycle are ignored.
- Store-to-TX latency is 1 cycle: `cpu_wr` at edge N gives `tx_valid`=1 and `tx_data`=word from edge N onward.
- RX-to-load latency is 1 cycle: an RX push at edge N makes the word appear on `read_in` after edge N.
- `read_in` and `cpu_hold` are combinational from state and strobes within the same cycle. The processor samples them before the next edge.
- Full condition is count == DEPTH; empty condition is count == 0. `tx_valid` and `rx_ready` are derived from registered counts only.

## Configuration
- `IO_BRIDGE_STALL_EN` defined:
  - `cpu_hold = (cpu_wr && tx_full && !tx_pop) || (cpu_rd && rx_empty)`.
  - A held access has no effect: no push, no pop, no flag set.
  - The processor keeps the strobe asserted until `cpu_hold` drops.
  - `overflow` and `underflow` are never set.
- `IO_BRIDGE_STALL_EN` undefined:
  - `cpu_hold` is tied 0.
  - A store to a full TX FIFO (with no same-cycle pop) is dropped and sets `overflow`.
  - A load from an empty RX FIFO returns `EMPTY_VALUE` and sets `underflow`.

## Test plan
- Reset, then `cpu_wr` with 16'h1234 and 16'h5678 on consecutive cycles, `tx_ready`=0 → `tx_valid`=1, `tx_data`=16'h1234, count 2. Raise `tx_ready` → 16'h1234 then 16'h5678 delivered, then `tx_valid`=0.
- With `DEPTH`=4, `tx_ready`=0, five stores 16'h0001..16'h0005:
  - no macro → 16'h0005 dropped, `overflow`=1, drain yields 1,2,3,4.
  - macro → `cpu_hold`=1 on the 5th store until `tx_ready` pulses, then 16'h0005 accepted.
- Full TX FIFO with `cpu_wr` and `tx_ready` high in the same cycle → both act, count stays 4, order preserved.
- Producer pushes 16'hA5A5 and 16'h0F0F → `rx_ready` stays 1. Two `cpu_rd` return 16'hA5A5 then 16'h0F0F, then `read_in`=`EMPTY_VALUE`. A third `cpu_rd` sets `underflow` (no macro) or raises `cpu_hold` (macro).
- Fill RX with 4 words → `rx_ready`=0. Assert `rx_valid` and `cpu_rd` together → pop only. `rx_ready`=1 next cycle.
- Assert `rst` with 3 words in each FIFO → next cycle `tx_valid`=0, `rx_ready`=1, flags 0, `read_in`=`EMPTY_VALUE`.

Source files
------------

// File: rtl/io_port_bridge.sv
// io_port_bridge: memory-side I/O bridge for the 16-bit pipelined processor.
// Processor stores are queued in a TX FIFO towards an external consumer and
// words from an external producer are queued in an RX FIFO for processor loads.
// Both sides use valid/ready handshakes.
//
// Build option: define IO_BRIDGE_STALL_EN to stall the processor (cpu_hold)
// on a store to a full TX FIFO or a load from an empty RX FIFO, instead of
// dropping the store / returning EMPTY_VALUE and setting the sticky flags.
module io_port_bridge #(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] EMPTY_VALUE = 16'h0000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] write_out,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [15:0] read_in,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cpu_hold,
    output logic        overflow,
    output logic        underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [15:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] tx_count;
    logic [15:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] rx_count;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic overflow_set, underflow_set;

    // Status and handshake decode from the registered counts.
    always_comb begin
        tx_full  = (tx_count == FULL_CNT);
        tx_empty = (tx_count == '0);
        rx_full  = (rx_count == FULL_CNT);
        rx_empty = (rx_count == '0);
        tx_valid = !tx_empty;
        rx_ready = !rx_full;
        tx_pop   = tx_valid && tx_ready;
        // A full TX FIFO still takes a store when its head leaves this cycle.
        tx_push  = cpu_wr && (!tx_full || tx_pop);
        rx_push  = rx_valid && rx_ready;
        rx_pop   = cpu_rd && !rx_empty;
        tx_data  = tx_mem[tx_rd_ptr];
        read_in  = rx_empty ? EMPTY_VALUE : rx_mem[rx_rd_ptr];
    end

`ifdef IO_BRIDGE_STALL_EN
    // Blocked accesses are held off; push/pop qualifiers already exclude them.
    always_comb begin
        cpu_hold      = (cpu_wr && tx_full && !tx_pop) || (cpu_rd && rx_empty);
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
    end
`else
    // Blocked accesses complete immediately and are recorded in sticky flags.
    always_comb begin
        cpu_hold      = 1'b0;
        overflow_set  = cpu_wr && tx_full && !tx_pop;
        underflow_set = cpu_rd && rx_empty;
    end
`endif

    // FIFO storage; contents need no reset since counts gate visibility.
    always_ff @(posedge clock) begin
        if (!rst && tx_push) tx_mem[tx_wr_ptr] <= write_out;
        if (!rst && rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    // TX pointers and occupancy.
    always_ff @(posedge clock) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX pointers and occupancy.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (overflow_set)  overflow  <= 1'b1;
            if (underflow_set) underflow <= 1'b1;
        end
    end

endmodule
